// File: rtl/rv32_bus_ram.sv
// rtl/rv32_bus_ram.sv - word-addressed RAM responder for one rv32 memory bus
// Optional BUS_RAM_FAULT_EN adds a registered fault_out flag for out-of-range or both-high accesses.
module rv32_bus_ram #(
   parameter int unsigned DEPTH        = 1024,
   parameter logic [31:0] BASE_ADDRESS = 32'h0,
   parameter int unsigned LATENCY      = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address_in,
   input  logic        read_in,
   input  logic        write_in,
   input  logic [3:0]  write_mask_in,
   input  logic [31:0] write_value_in,
   output logic [31:0] read_value_out,
   output logic        ready_out
`ifdef BUS_RAM_FAULT_EN
   ,
   output logic        fault_out
`endif
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
   localparam logic [3:0]  WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t        state;
   state_t        next_state;
   logic [3:0]    count;
   logic [3:0]    count_next;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] cap_index;
   logic          cap_write;
   logic          cap_in_range;
   logic [3:0]    cap_mask;
   logic [31:0]   cap_value;

   logic [31:0]   offset;
   logic          live_in_range;
   logic          request;
   logic          capture;

   logic [AW-1:0] cur_index;
   logic          cur_write;
   logic          cur_in_range;
   logic [3:0]    cur_mask;
   logic [31:0]   cur_value;

   logic          enter_ack;
   logic          commit;
   logic          read_hit;

   assign offset        = address_in - BASE_ADDRESS;
   assign live_in_range = {1'b0, offset} < SPAN;
   assign request       = read_in | write_in;
   assign capture       = (state == S_IDLE) && request;

   // With no wait states ACK is entered on the capture edge, so the live bus is used directly.
   assign cur_index    = (state == S_IDLE) ? offset[AW+1:2] : cap_index;
   assign cur_write    = (state == S_IDLE) ? write_in       : cap_write;
   assign cur_in_range = (state == S_IDLE) ? live_in_range  : cap_in_range;
   assign cur_mask     = (state == S_IDLE) ? write_mask_in  : cap_mask;
   assign cur_value    = (state == S_IDLE) ? write_value_in : cap_value;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= 4'd0;
         ready_out <= 1'b0;
      end else begin
         state     <= next_state;
         count     <= count_next;
         ready_out <= enter_ack;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (request) next_state = (LATENCY == 0) ? S_ACK : S_WAIT;
         S_WAIT:  if (count == 4'd0) next_state = S_ACK;
         S_ACK:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      enter_ack  = (next_state == S_ACK);
      commit     = enter_ack && cur_write && cur_in_range && !reset;
      read_hit   = enter_ack && !cur_write && cur_in_range;
      count_next = count;
      if (capture)
         count_next = WAIT_LOAD;
      else if ((state == S_WAIT) && (count != 4'd0))
         count_next = count - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         cap_index    <= offset[AW+1:2];
         cap_write    <= write_in;
         cap_in_range <= live_in_range;
         cap_mask     <= write_mask_in;
         cap_value    <= write_value_in;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_mask[i]) mem[cur_index][8*i +: 8] <= cur_value[8*i +: 8];
         end
      end
   end

   // Read data is only non-zero during the ACK cycle of an in-range read.
   always_ff @(posedge clk) begin
      if (reset)
         read_value_out <= 32'h0;
      else if (read_hit)
         read_value_out <= mem[cur_index];
      else
         read_value_out <= 32'h0;
   end

`ifdef BUS_RAM_FAULT_EN
   logic cap_both;
   logic cur_both;

   assign cur_both = (state == S_IDLE) ? (read_in && write_in) : cap_both;

   always_ff @(posedge clk) begin
      if (capture) cap_both <= read_in && write_in;
   end

   always_ff @(posedge clk) begin
      if (reset)
         fault_out <= 1'b0;
      else
         fault_out <= enter_ack && (!cur_in_range || cur_both);
   end
`endif

endmodule

// File: tb/tb_rv32_bus_ram.sv
// tb/tb_rv32_bus_ram.sv - self-checking bench for rv32_bus_ram
// Two instances: LATENCY=0 at base 0x1000 (1024 words) and LATENCY=3 at base 0 (16 words).
module tb_rv32_bus_ram;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address_in = 32'h0;
   logic [3:0]  write_mask_in = 4'h0;
   logic [31:0] write_value_in = 32'h0;
   logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0] rv0, rv1;
   logic        rdy0, rdy1;
`ifdef BUS_RAM_FAULT_EN
   logic        f0, f1;
`endif

   int total = 0;
   int bad = 0;

   logic [31:0] m0 [1024];
   logic [31:0] m1 [16];

   always #5 clk = ~clk;

   rv32_bus_ram #(.DEPTH(1024), .BASE_ADDRESS(32'h1000), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .address_in(address_in), .read_in(rd0), .write_in(wr0),
      .write_mask_in(write_mask_in), .write_value_in(write_value_in),
      .read_value_out(rv0), .ready_out(rdy0)
`ifdef BUS_RAM_FAULT_EN
      , .fault_out(f0)
`endif
   );

   rv32_bus_ram #(.DEPTH(16), .BASE_ADDRESS(32'h0), .LATENCY(3)) dut1 (
      .clk(clk), .reset(reset), .address_in(address_in), .read_in(rd1), .write_in(wr1),
      .write_mask_in(write_mask_in), .write_value_in(write_value_in),
      .read_value_out(rv1), .ready_out(rdy1)
`ifdef BUS_RAM_FAULT_EN
      , .fault_out(f1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_in_range(input int sel, input logic [31:0] a);
      logic [31:0] off = a - (sel != 0 ? 32'h0 : 32'h1000);
      longint span = (sel != 0) ? 64 : 4096;
      return longint'(off) < span;
   endfunction

   function automatic logic [31:0] model_read(input int sel, input logic [31:0] a);
      logic [31:0] off = a - (sel != 0 ? 32'h0 : 32'h1000);
      if (!model_in_range(sel, a)) return 32'h0;
      return (sel != 0) ? m1[int'(off >> 2)] : m0[int'(off >> 2)];
   endfunction

   function automatic void model_write(input int sel, input logic [31:0] a, input logic [3:0] m,
                                       input logic [31:0] v);
      logic [31:0] off = a - (sel != 0 ? 32'h0 : 32'h1000);
      logic [31:0] w;
      if (!model_in_range(sel, a)) return;
      w = model_read(sel, a);
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = v[8*i +: 8];
      if (sel != 0) m1[int'(off >> 2)] = w;
      else m0[int'(off >> 2)] = w;
   endfunction

   task automatic access(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] v, input string tag,
                         output logic [31:0] rv_got);
      logic [31:0] exp_rv;
      logic        exp_f;
      logic        fv;
      logic        got;
      int          k;
      int          lat;
      lat    = (sel != 0) ? 3 : 0;
      exp_rv = wr ? 32'h0 : model_read(sel, a);
      exp_f  = !model_in_range(sel, a) || (rd && wr);
      rv_got = 32'hX;
      fv     = 1'b0;
      @(negedge clk);
      address_in = a; write_mask_in = m; write_value_in = v;
      if (sel != 0) begin rd1 = rd; wr1 = wr; end
      else begin rd0 = rd; wr0 = wr; end
      got = 1'b0;
      k = 0;
      while (!got && k < 40) begin
         @(posedge clk); #1;
         k++;
         if ((sel != 0) ? rdy1 : rdy0) begin
            got = 1'b1;
            rv_got = (sel != 0) ? rv1 : rv0;
`ifdef BUS_RAM_FAULT_EN
            fv = (sel != 0) ? f1 : f0;
`endif
         end
      end
      chk({tag, "_latency"}, 32'(k), 32'(1 + lat));
      @(negedge clk);
      rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
      if (got) begin
         chk({tag, "_rdata"}, rv_got, exp_rv);
`ifdef BUS_RAM_FAULT_EN
         chk({tag, "_fault"}, {31'b0, fv}, {31'b0, exp_f});
`endif
      end
      @(posedge clk); #1;
      chk({tag, "_ready_drop"}, {31'b0, (sel != 0) ? rdy1 : rdy0}, 32'h0);
      chk({tag, "_rdata_clear"}, (sel != 0) ? rv1 : rv0, 32'h0);
      if (wr) model_write(sel, a, m, v);
   endtask

   initial begin
      logic [31:0] r;
      logic        seen;
      int          kind;
      int          sel;
      logic [31:0] a;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready0", {31'b0, rdy0}, 32'h0);
      chk("reset_ready1", {31'b0, rdy1}, 32'h0);
      chk("reset_rdata0", rv0, 32'h0);
`ifdef BUS_RAM_FAULT_EN
      chk("reset_fault0", {31'b0, f0}, 32'h0);
`endif
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         access(0, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 4'hF, $urandom, "init0", r);
         access(1, 1'b0, 1'b1, 32'(4 * i), 4'hF, $urandom, "init1", r);
      end
      access(0, 1'b0, 1'b1, 32'h1FFC, 4'hF, 32'hA5A5_5A5A, "init0_top", r);

      access(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, "read_word0", r);

      access(0, 1'b0, 1'b1, 32'h1010, 4'hF, 32'h1122_3344, "mw_init", r);
      access(0, 1'b0, 1'b1, 32'h1010, 4'b0101, 32'hDEAD_BEEF, "mw_write", r);
      access(0, 1'b1, 1'b0, 32'h1010, 4'h0, 32'h0, "mw_read", r);
      chk("mw_value", r, 32'h11AD_33EF);

      access(0, 1'b0, 1'b1, 32'h1014, 4'h0, 32'hFFFF_FFFF, "mask0_write", r);
      access(0, 1'b1, 1'b0, 32'h1014, 4'h0, 32'h0, "mask0_read", r);

      access(0, 1'b1, 1'b0, 32'h2000, 4'h0, 32'h0, "oor_read", r);
      chk("oor_read_zero", r, 32'h0);
      access(0, 1'b0, 1'b1, 32'h0FFC, 4'hF, 32'h1234_5678, "oor_write", r);
      access(0, 1'b1, 1'b0, 32'h1FFC, 4'h0, 32'h0, "oor_alias", r);
      chk("oor_alias_kept", r, 32'hA5A5_5A5A);

      access(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, "lat3_read", r);

      @(negedge clk);
      address_in = 32'h8; rd1 = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         @(posedge clk); #1;
         chk($sformatf("held_c%0d", c), {31'b0, rdy1}, {31'b0, (c == 4 || c == 9)});
         if (c == 4 || c == 9) chk($sformatf("held_rdata_c%0d", c), rv1, model_read(1, 32'h8));
      end
      @(negedge clk);
      rd1 = 1'b0;
      @(posedge clk); #1;
      chk("held_end", {31'b0, rdy1}, 32'h0);

      @(negedge clk);
      address_in = 32'h8; write_mask_in = 4'hF; write_value_in = 32'hCAFE_F00D; wr1 = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      seen = rdy1;
      @(posedge clk); #1;
      seen = seen | rdy1;
      @(negedge clk);
      reset = 1'b0; wr1 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         seen = seen | rdy1;
      end
      chk("rst_wait_no_ready", {31'b0, seen}, 32'h0);
      access(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, "rst_wait_read", r);

      access(1, 1'b1, 1'b1, 32'h4, 4'hF, 32'h5, "both_high", r);
      access(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, "both_read", r);
      chk("both_value", r, 32'h5);

      for (int n = 0; n < 40; n++) begin
         sel  = int'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 2));
         if ($urandom_range(0, 4) == 0)
            a = ((sel != 0) ? 32'h40 : 32'h2000) + 32'(4 * $urandom_range(0, 255));
         else
            a = ((sel != 0) ? 32'h0 : 32'h1000) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         access(sel, kind != 1, kind != 0, a, 4'($urandom), $urandom, $sformatf("rnd%0d", n), r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
